count_seq_checker: RTL
======================

// Module: count_seq_checker
// PURPOSE
//  Reader end of the 4-bit counter path: samples the QOUT bus of an up or down
//  counter (synchronous adder, synchronous subtractor, ripple adder) and checks
//  that each sample is exactly one step from the previous one, modulo 2^WIDTH.
//  Reports lock status, one-cycle error and wrap pulses, and a saturating error
//  count. Sits beside the counter in benches and on-board self-test.
// PARAMETERS
//  WIDTH     4   width of the checked count bus
//  LOCK_CNT  2   consecutive correct steps needed to enter LOCK (>=1)
//  ERR_W     8   width of ERR_CNT
// PORTS
//  CLK         in   1      system clock, rising edge
//  RESET       in   1      asynchronous, active-low reset
//  EN          in   1      sample enable; QIN is sampled on CLK rise when EN=1
//  DIR         in   1      expected direction: 1 = up (+1), 0 = down (-1)
//  QIN         in   WIDTH  count value under check
//  LOCKED      out  1      1 while state is LOCK
//  ERR_PULSE   out  1      1-cycle pulse on a step error detected in LOCK
//  WRAP_PULSE  out  1      1-cycle pulse on a correct wrap step in LOCK
//  ERR_CNT     out  ERR_W  saturating count of errors since reset
//  LAST_Q      out  WIDTH  last sampled QIN
// BEHAVIOUR
//  - RESET=0 (any time, asynchronous): state IDLE, run=0, prev=0, prev_dir=0,
//    LOCKED=0, ERR_PULSE=0, WRAP_PULSE=0, ERR_CNT=0, LAST_Q=0.
//  - All outputs are registered. The effect of the sample taken at edge N is
//    visible after edge N. ERR_PULSE and WRAP_PULSE are high for exactly one cycle.
//  - EN=0: no sample; state, run, prev, ERR_CNT and LAST_Q hold; pulses are 0.
//  - Every sample: prev<=QIN, LAST_Q<=QIN, prev_dir<=DIR.
//  - Expected value exp = prev+1 when DIR=1, prev-1 when DIR=0, both mod 2^WIDTH.
//    A match is QIN==exp. A held value (QIN==prev) is a mismatch.
//  - States:
//    IDLE: the first sample stores prev and moves to ACQ with run=0. No check.
//    ACQ : match -> run+1. If run+1==LOCK_CNT -> LOCK and run=0.
//          mismatch -> run=0, stay in ACQ. No error is counted in ACQ.
//    LOCK: match -> stay in LOCK. If it is a wrap step (up: prev=2^WIDTH-1,
//          QIN=0; down: prev=0, QIN=2^WIDTH-1) -> WRAP_PULSE.
//          mismatch -> ERR_PULSE, ERR_CNT+1 (saturates at 2^ERR_W-1),
//          go to ACQ with run=0.
//  - Direction change: a sample with DIR!=prev_dir in ACQ or LOCK is not
//    checked. It goes to ACQ with run=0, with no error and no wrap.
//  - Wrap steps in ACQ count as matches but give no WRAP_PULSE.
//  - A counter RESET pulse (QOUT jumps to 0) while LOCKED is one error. The
//    checker then relocks after LOCK_CNT further correct steps.
// TESTING
//  1 Up sequence 0,1,2,...,15,0,1 with EN=1, DIR=1 -> LOCKED=1 after the 3rd
//    sample; one WRAP_PULSE on the 15->0 step; ERR_CNT=0.
//  2 Down sequence 5,4,3,2,1,0,15,14 with DIR=0 -> LOCKED after 3rd sample;
//    WRAP_PULSE on 0->15; ERR_CNT=0.
//  3 Locked up run 3,4,5, then 9,10,11 -> ERR_PULSE for 1 cycle after the 9
//    sample; ERR_CNT=1; LOCKED=0 for 2 samples, then 1 again after 11.
//  4 Held value 6,7,8,8 while locked -> ERR_PULSE once; ERR_CNT=1. Then toggle
//    DIR mid-run -> LOCKED drops, ERR_CNT stays 1.
//  5 EN=0 for 10 cycles with QIN changing randomly while locked -> all outputs
//    hold, no pulses; resume with 12,13 after prev=11 -> still LOCKED.
//  6 RESET=0 asynchronously mid-cycle while locked with ERR_CNT=3 -> all outputs
//    0 immediately, no clock edge needed; ERR_W=2 with 5 forced errors ->
//    ERR_CNT saturates at 3.

Source files
------------

// File: rtl/count_seq_checker.sv
// -----------------------------------------------------------------------------
// count_seq_checker
//
// Reader end of a WIDTH-bit counter path. Samples a counter's output bus and
// checks that every sample is exactly one step (+1 when counting up, -1 when
// counting down, modulo 2^WIDTH) away from the previous sample.
//
// After LOCK_CNT consecutive correct steps the checker is locked. While locked,
// a bad step raises a one-cycle error pulse and bumps a saturating error count.
// A correct wrap step (max->0 up, 0->max down) raises a one-cycle wrap pulse.
//
// Ports
//   clk_i         in   1      clock, rising edge
//   rst_ni        in   1      asynchronous active-low reset
//   en_i          in   1      sample enable; qin_i is sampled when high
//   dir_i         in   1      expected direction: 1 = up, 0 = down
//   qin_i         in   WIDTH  count value under check
//   locked_o      out  1      high while in LOCK
//   err_pulse_o   out  1      one-cycle pulse on a step error seen in LOCK
//   wrap_pulse_o  out  1      one-cycle pulse on a correct wrap step in LOCK
//   err_cnt_o     out  ERR_W  saturating error count since reset
//   last_q_o      out  WIDTH  last sampled qin_i
// -----------------------------------------------------------------------------
module count_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic [WIDTH-1:0] qin_i,
  output logic             locked_o,
  output logic             err_pulse_o,
  output logic             wrap_pulse_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [WIDTH-1:0] last_q_o
);

  // Run counter only ever holds 0..LOCK_CNT-1; one extra bit of headroom keeps
  // the incremented value representable when comparing against LOCK_CNT.
  localparam int RUN_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  state_t             state_q,      state_d;
  logic [RUN_W-1:0]   run_q,        run_d;
  logic [WIDTH-1:0]   prev_q,       prev_d;
  logic               prev_dir_q,   prev_dir_d;
  logic [ERR_W-1:0]   err_cnt_q,    err_cnt_d;
  logic               err_pulse_q,  err_pulse_d;
  logic               wrap_pulse_q, wrap_pulse_d;

  // Step evaluation against the previous sample
  logic [WIDTH-1:0]   exp_val;
  logic               step_match;
  logic               dir_change;
  logic               wrap_step;
  logic [RUN_W-1:0]   run_inc;
  logic               err_sat;

  assign exp_val    = dir_i ? (prev_q + WIDTH'(1)) : (prev_q - WIDTH'(1));
  assign step_match = (qin_i == exp_val);
  assign dir_change = (dir_i != prev_dir_q);
  // Only meaningful when step_match is true: the match already pins qin_i to
  // 0 (up) or all-ones (down), so looking at prev_q alone identifies a wrap.
  assign wrap_step  = dir_i ? (prev_q == {WIDTH{1'b1}}) : (prev_q == {WIDTH{1'b0}});
  assign run_inc    = run_q + RUN_W'(1);
  assign err_sat    = &err_cnt_q;

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    prev_d       = prev_q;
    prev_dir_d   = prev_dir_q;
    err_cnt_d    = err_cnt_q;
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;

    if (en_i) begin
      prev_d     = qin_i;
      prev_dir_d = dir_i;

      unique case (state_q)
        ST_IDLE: begin
          // First sample only seeds the reference value.
          state_d = ST_ACQ;
          run_d   = '0;
        end

        ST_ACQ: begin
          if (dir_change) begin
            run_d = '0;
          end else if (step_match) begin
            if (run_inc == RUN_W'(LOCK_CNT)) begin
              state_d = ST_LOCK;
              run_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end else begin
            run_d = '0;
          end
        end

        ST_LOCK: begin
          if (dir_change) begin
            // A direction change is a re-acquisition, not a fault.
            state_d = ST_ACQ;
            run_d   = '0;
          end else if (step_match) begin
            wrap_pulse_d = wrap_step;
          end else begin
            err_pulse_d = 1'b1;
            if (!err_sat) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            state_d = ST_ACQ;
            run_d   = '0;
          end
        end

        default: begin
          state_d = ST_IDLE;
          run_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      run_q        <= '0;
      prev_q       <= '0;
      prev_dir_q   <= 1'b0;
      err_cnt_q    <= '0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      prev_q       <= prev_d;
      prev_dir_q   <= prev_dir_d;
      err_cnt_q    <= err_cnt_d;
      err_pulse_q  <= err_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  // All outputs come straight from registers. The last sample and the
  // reference value are the same quantity, so one register serves both.
  assign locked_o     = (state_q == ST_LOCK);
  assign err_pulse_o  = err_pulse_q;
  assign wrap_pulse_o = wrap_pulse_q;
  assign err_cnt_o    = err_cnt_q;
  assign last_q_o     = prev_q;

endmodule
